// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
// Round-robin scheduler that shares one DW-bit SPI transmit engine among
// N_REQ requesters. It latches the winner's word, pulses tx_start, waits for
// tx_done (or a watchdog timeout), acks the requester, then holds a minimum
// idle gap before the next arbitration.
//
// Ports:
//   clk       rising-edge system clock
//   reset     synchronous, active-low reset
//   req       per-requester request level
//   req_data  packed request words, requester i at [i*DW +: DW]
//   ack       one-cycle pulse on the served requester when its frame completes
//   err       one-cycle pulse when the watchdog aborts a frame
//   busy      high whenever the FSM is not idle
//   grant_id  index of the requester currently or last served
//   tx_start  one-cycle start pulse to the engine
//   tx_data   word for the engine, stable from tx_start until the next grant
//   tx_done   one-cycle end-of-frame pulse from the engine
module spi_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 16,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         ack,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     tx_start,
  output logic [DW-1:0]            tx_data,
  input  logic                     tx_done
);

  localparam int IW    = $clog2(N_REQ);
  localparam int TW    = $clog2(TIMEOUT);
  localparam int GAP_N = (GAP < 1) ? 1 : GAP;
  localparam int GW    = $clog2(GAP_N + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     sel_idx;
  logic              sel_found;
  logic [TW-1:0]     timer;
  logic [GW-1:0]     gap_cnt;
  logic              done_hit;
  logic              to_hit;
  logic [N_REQ-1:0]  ack_nxt;

  // Round-robin pick: first set req bit searching upward from last_grant+1.
  always_comb begin
    int cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_grant) + i) % N_REQ;
      if (!sel_found && req[IW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(cand);
      end
    end
  end

  // Next-state and pulse decode. tx_done is only looked at in WAIT, and it
  // takes priority over the watchdog limit in the same cycle.
  always_comb begin
    state_nxt = state;
    done_hit  = 1'b0;
    to_hit    = 1'b0;
    ack_nxt   = '0;
    case (state)
      S_IDLE:  if (sel_found) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          done_hit          = 1'b1;
          ack_nxt[grant_id] = 1'b1;
          state_nxt         = S_GAP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          to_hit    = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP:   if (gap_cnt == GW'(GAP_N - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      ack        <= '0;
      err        <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
      last_grant <= IW'(N_REQ - 1);
    end else begin
      state <= state_nxt;
      ack   <= ack_nxt;
      err   <= to_hit;
      case (state)
        S_IDLE: begin
          // req_data is captured only here; later changes are ignored.
          if (sel_found) begin
            tx_data  <= req_data[int'(sel_idx)*DW +: DW];
            grant_id <= sel_idx;
          end
        end
        S_START: timer <= '0;
        S_WAIT: begin
          if (done_hit || to_hit) begin
            last_grant <= grant_id;
            gap_cnt    <= '0;
          end else begin
            // Never wraps: WAIT exits at TIMEOUT-1 at the latest.
            timer <= timer + TW'(1);
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

  assign tx_start = (state == S_START);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: a scoreboard queue holds the expected
// (grant_id, tx_data) of every frame; a monitor pops it on each tx_start.
// Scenario tasks drive requests and the engine's tx_done and check acks,
// error pulses and cycle timing inline.
module tb_spi_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      ack;
  logic              err, busy, tx_start, tx_done;
  logic [1:0]        grant_id;
  logic [DW-1:0]     tx_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          id;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  spi_tx_arbiter #(.N_REQ(N), .DW(DW), .GAP(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // Scoreboard: every start must match the oldest expected grant.
  always @(negedge clk) begin
    if (reset === 1'b1 && tx_start === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_start: got id=%0d data=%h, required no start", grant_id, tx_data);
      end else begin : pop
        exp_t e;
        e = sb.pop_front();
        if (grant_id !== 2'(e.id) || tx_data !== e.data) begin
          errors++;
          $display("FAIL sb_grant: got id=%0d data=%h, required id=%0d data=%h",
                   grant_id, tx_data, e.id, e.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation ran past its time limit, required completion");
    $fatal(1);
  end

  task automatic set_word(input int i, input logic [15:0] w);
    req_data[i*DW +: DW] = w;
  endtask

  task automatic push(input int id);
    exp_t e;
    e.id   = id;
    e.data = req_data[id*DW +: DW];
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    reset    = 1'b0;
    req      = '0;
    tx_done  = 1'b0;
    req_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.delete();
  endtask

  // Waits for tx_start, then plays the engine: tx_done in cycle dly counted
  // from the tx_start cycle (dly<0: never). Requesters drop req on ack.
  // Returns at the negedge of the first idle cycle.
  task automatic do_frame(input int dly, output int start_wait, output logic [3:0] ack_or,
                          output int ack_cyc, output int n_ack, output int err_cyc,
                          output int idle_cyc);
    start_wait = -1; ack_or = '0; ack_cyc = -1; n_ack = 0; err_cyc = -1; idle_cyc = -1;
    tx_done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        start_wait = k;
        break;
      end
    end
    if (start_wait < 0) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: no tx_start within 40 cycles, required one");
      return;
    end
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (ack !== '0) begin
        ack_or |= ack;
        n_ack++;
        if (ack_cyc < 0) ack_cyc = c;
        req = req & ~ack;
      end
      if (err === 1'b1 && err_cyc < 0) err_cyc = c;
      tx_done = (c == dly);
      if (busy === 1'b0) begin
        idle_cyc = c;
        break;
      end
    end
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b1111; tx_done = 1'b1; req_data = '1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b, required 0", tx_start); end
    checks++; if (ack !== 4'b0000)   begin errors++; $display("FAIL reset_ack: got %b, required 0000", ack); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
    checks++; if (tx_data !== 16'h0) begin errors++; $display("FAIL reset_tx_data: got %h, required 0000", tx_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
    apply_reset();
  endtask

  task automatic test_single();
    int sw, ac, na, ec, ic;
    logic [3:0] ao;
    apply_reset();
    set_word(0, 16'hA5F0);
    push(0);
    req = 4'b0001;
    do_frame(20, sw, ao, ac, na, ec, ic);
    checks++; if (sw !== 1)       begin errors++; $display("FAIL single_start_lat: got %0d, required 1", sw); end
    checks++; if (ao !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b, required 0001", ao); end
    checks++; if (ac !== 21)      begin errors++; $display("FAIL single_ack_cycle: got %0d, required 21", ac); end
    checks++; if (na !== 1)       begin errors++; $display("FAIL single_ack_len: got %0d, required 1", na); end
    checks++; if (ec !== -1)      begin errors++; $display("FAIL single_err: got %0d, required -1", ec); end
    checks++; if (ic !== 23)      begin errors++; $display("FAIL single_busy_low: got %0d, required 23", ic); end
  endtask

  task automatic test_all_four();
    int sw, ac, na, ec, ic;
    logic [3:0] ao;
    apply_reset();
    set_word(0, 16'h1111); set_word(1, 16'h2222);
    set_word(2, 16'h3333); set_word(3, 16'h4444);
    for (int i = 0; i < 4; i++) push(i);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      do_frame(3 + i, sw, ao, ac, na, ec, ic);
      checks++; if (ao !== 4'(1 << i)) begin errors++; $display("FAIL all4_ack[%0d]: got %b, required %b", i, ao, 4'(1 << i)); end
      checks++; if (na !== 1) begin errors++; $display("FAIL all4_ack_count[%0d]: got %0d, required 1", i, na); end
    end
  endtask

  task automatic test_fairness();
    int sw, ac, na, ec, ic, id;
    logic [3:0] ao;
    apply_reset();
    set_word(0, 16'hC0DE); set_word(2, 16'hF00D);
    req = 4'b0101;
    for (int f = 0; f < 8; f++) begin
      id = (f % 2 == 0) ? 0 : 2;
      push(id);
      do_frame(4, sw, ao, ac, na, ec, ic);
      checks++; if (ao !== 4'(1 << id)) begin errors++; $display("FAIL fair_ack[%0d]: got %b, required %b", f, ao, 4'(1 << id)); end
      if (f < 7) req = req | 4'b0101;
      else       req = '0;
    end
  endtask

  task automatic test_timeout();
    int sw, ac, na, ec, ic;
    logic [3:0] ao;
    apply_reset();
    set_word(1, 16'h0B0B); set_word(2, 16'h0C0C);
    push(1);
    req = 4'b0110;
    do_frame(-1, sw, ao, ac, na, ec, ic);
    checks++; if (ec !== 65) begin errors++; $display("FAIL timeout_err_cycle: got %0d, required 65", ec); end
    checks++; if (na !== 0)  begin errors++; $display("FAIL timeout_no_ack: got %0d acks, required 0", na); end
    checks++; if (ic !== 67) begin errors++; $display("FAIL timeout_idle: got %0d, required 67", ic); end
    req[1] = 1'b0;
    push(2);
    do_frame(6, sw, ao, ac, na, ec, ic);
    checks++; if (ao !== 4'b0100) begin errors++; $display("FAIL timeout_next_ack: got %b, required 0100", ao); end
  endtask

  task automatic test_tie();
    int sw, ac, na, ec, ic;
    logic [3:0] ao;
    apply_reset();
    set_word(0, 16'h7E57);
    push(0);
    req = 4'b0001;
    do_frame(64, sw, ao, ac, na, ec, ic);
    checks++; if (ao !== 4'b0001) begin errors++; $display("FAIL tie_ack: got %b, required 0001", ao); end
    checks++; if (ac !== 65)      begin errors++; $display("FAIL tie_ack_cycle: got %0d, required 65", ac); end
    checks++; if (ec !== -1)      begin errors++; $display("FAIL tie_err: got %0d, required -1", ec); end
  endtask

  task automatic test_reset_midframe();
    int sw, ac, na, ec, ic;
    logic [3:0] ao;
    bit seen;
    apply_reset();
    set_word(0, 16'hBEEF); set_word(3, 16'h3A3A);
    push(0);
    req = 4'b0001;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (tx_start === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_start: no tx_start, required one"); end
    set_word(0, 16'h1357);
    repeat (4) @(negedge clk);
    checks++; if (tx_data !== 16'hBEEF) begin errors++; $display("FAIL midrst_data_hold: got %h, required beef", tx_data); end
    checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL midrst_busy: got %b, required 1", busy); end
    reset = 1'b0; req = '0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (busy !== 1'b0 || tx_start !== 1'b0 || ack !== 4'b0 || err !== 1'b0)
      begin errors++; $display("FAIL midrst_ctrl: got busy=%b start=%b ack=%b err=%b, required all 0", busy, tx_start, ack, err); end
    checks++; if (tx_data !== 16'h0 || grant_id !== 2'd0)
      begin errors++; $display("FAIL midrst_regs: got data=%h id=%0d, required 0000 0", tx_data, grant_id); end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 4'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL midrst_stale_done: got ack=%b busy=%b, required 0000 0", ack, busy); end
    push(3);
    req = 4'b1000;
    do_frame(5, sw, ao, ac, na, ec, ic);
    checks++; if (ao !== 4'b1000) begin errors++; $display("FAIL midrst_next_ack: got %b, required 1000", ao); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_timeout();
    test_tie();
    test_reset_midframe();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending grants, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
# spi_tx_arbiter

Round-robin scheduler that shares one 16-bit SPI transmit engine among several requesters. It latches the winning requester's word and starts the engine. It then waits for end-of-frame, acknowledges the requester and enforces a minimum idle gap between frames. A watchdog aborts a frame whose end-of-frame never arrives. The block sits between the register/command sources and the `spi_state` serializer.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (≥2).
- `DW`, 16: frame data width.
- `GAP`, 2: minimum idle cycles between frames. Values 0 and 1 both give 1 cycle.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before abort (≥2).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `req_data`  in  N_REQ*DW  packed words; requester i at `[i*DW +: DW]`.
- `ack`  out  N_REQ  one-cycle pulse on the served requester's bit when its frame completes.
- `err`  out  1  one-cycle pulse on watchdog abort.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant_id`  out  $clog2(N_REQ)  index of the requester currently or last served.
- `tx_start`  out  1  one-cycle start pulse to the engine.
- `tx_data`  out  DW  word for the engine; held stable from `tx_start` until the next grant.
- `tx_done`  in  1  one-cycle end-of-frame pulse from the engine.

## Operation
- State machine with four states: IDLE, START, WAIT, GAP.
- IDLE:
  - If any `req` bit is high, select the first set bit searching upward from `last_grant+1`, wrapping modulo N_REQ.
  - Latch that bit's word into `tx_data` and its index into `grant_id`, then go to START.
  - With no request, stay in IDLE.
- START: `tx_start`=1 for exactly this one cycle; clear the timer; go to WAIT.
- WAIT: timer increments every cycle.
  - `tx_done`=1: pulse `ack[grant_id]`, set `last_grant`=`grant_id`, go to GAP.
  - Otherwise, when the timer reaches TIMEOUT-1: pulse `err`, set `last_grant`=`grant_id` (no `ack`), go to GAP.
  - `tx_done` and the timeout limit in the same cycle: done wins, so `ack` pulses and `err` does not.
- GAP: stay max(GAP,1) cycles, then go to IDLE.
- `tx_done` is ignored in IDLE, START and GAP.
- Requester protocol:
  - Hold `req` high until `ack`, then drop it or it counts as a new request.
  - The GAP state lets the requester drop `req` after `ack` before the next arbitration.
  - Dropping `req` before the grant means the requester is simply not selected.
  - Dropping `req` after the grant does not cancel the frame; `ack` still pulses.
- `req_data` is sampled only on the IDLE→START edge. Later changes do not affect `tx_data`.
- Reset, whether idle or mid-frame, puts every output at its reset value on the next edge:
  - state=IDLE; `ack`=0, `err`=0, `tx_start`=0, `busy`=0.
  - `tx_data`=0, `grant_id`=0, timer=0.
  - `last_grant`=N_REQ-1, so requester 0 has first priority.
  - A `tx_done` from a frame aborted by reset produces no `ack`.

## Timing
- All outputs are registered or decoded directly from the state register; there are no combinational paths from inputs to outputs.
- `req` sampled high in IDLE at edge k: `tx_start`, `busy`, `tx_data` and `grant_id` are valid in the cycle after edge k.
- `tx_done` sampled at edge m: `ack` is high for the single cycle after edge m.
  - GAP covers the cycles m+1 … m+max(GAP,1); state returns to IDLE at the following edge.
  - The earliest next `tx_start` is max(GAP,1)+2 cycles after `tx_done`.
- Abort: `err` is high in cycle TIMEOUT+1 counted from the `tx_start` cycle (cycle 0).
- The timer is `$clog2(TIMEOUT)` bits wide and never wraps, because WAIT always exits at TIMEOUT-1.
- Throughput: one frame per (frame length + max(GAP,1) + 2) cycles under continuous load.

## Test plan
- Single request: release reset, `req`=0001, word0=16'hA5F0, `tx_done` 20 cycles after `tx_start` → `tx_start` 1 cycle after `req`, `tx_data`=A5F0, `grant_id`=0, `ack`=0001 for 1 cycle, `busy` low 3 cycles after `tx_done` (GAP=2).
- All four requesting at once with words 1111/2222/3333/4444 → frames served in order 0,1,2,3, each `ack`ed exactly once, `tx_data` matching each word.
- Fairness: `req[0]` and `req[2]` held high and re-requested after every `ack` → grants alternate 0,2,0,2 over 8 frames with no starvation.
- Timeout: TIMEOUT=64, `req`=0010, `tx_done` never asserted → `err` pulse 65 cycles after `tx_start`, no `ack`, then a pending `req[2]` is served next.
- Done/timeout tie: `tx_done` asserted exactly in the cycle the timer reaches 63 → `ack` pulses, `err` stays 0.
- Reset mid-frame: reset low for 1 cycle during WAIT, then `tx_done` pulsed → every output at its reset value after that edge, no `ack`, next `req`=1000 granted normally with `grant_id`=3.
